wide_add_seq: RTL and testbench



---
 rtl/wide_add_pkg.sv | 5 +
 rtl/wide_add_seq_add3_slice.sv | 12 +
 rtl/wide_add_seq.sv | 83 ++++++++
 tb/tb_wide_add_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// wide_add_pkg: FSM state type and adder slice width shared by wide_add_seq and add3_slice
package wide_add_pkg;
  localparam int SLICE_W = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/wide_add_seq_add3_slice.sv
// add3_slice: combinational 3-bit adder slice with carry in and carry out
module add3_slice
  import wide_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: WIDTH-bit add built from one 3-bit slice, one slice per clock, valid/ready on both sides
// Optional subtract (op_a - op_b) when WIDE_ADD_SEQ_SUB_EN is defined.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IW = SLICES > 1 ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);
  if (WIDTH < SLICE_W || WIDTH % SLICE_W != 0) begin : g_bad_width
    $error("wide_add_seq: WIDTH must be a positive multiple of 3");
  end
  state_t state;
  logic [WIDTH-1:0] a_q, b_q, b_in;
  logic [IW-1:0] idx;
  logic carry, c_in, s_co;
  logic [SLICE_W-1:0] a_s, b_s, s_sum;
`ifdef WIDE_ADD_SEQ_SUB_EN
  // two's complement subtract: invert B and seed the carry chain with 1
  assign b_in = op_sub ? ~op_b : op_b;
  assign c_in = op_sub;
`else
  logic unused_sub;
  assign unused_sub = op_sub;
  assign b_in = op_b;
  assign c_in = 1'b0;
`endif
  assign a_s = SLICE_W'(a_q >> (SLICE_W * int'(idx)));
  assign b_s = SLICE_W'(b_q >> (SLICE_W * int'(idx)));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  add3_slice u_slice (
    .a (a_s),
    .b (b_s),
    .ci(carry),
    .s (s_sum),
    .co(s_co)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      result <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= op_a;
          b_q <= b_in;
          idx <= '0;
          carry <= c_in;
          result <= '0;
          state <= RUN;
        end
        RUN: begin
          result[SLICE_W*idx +: SLICE_W] <= s_sum;
          carry <= s_co;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            carry_out <= s_co;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: randomized and directed checks of wide_add_seq against a cycle-count/arithmetic model
module tb_wide_add_seq;
  localparam int W = 12, S = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, op_sub = 0, out_ready = 0;
  logic in_ready, out_valid, carry_out;
  logic [W-1:0] op_a = '0, op_b = '0, result;
  int checks = 0, errors = 0;
  wide_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit en;
    en = 0;
`ifdef WIDE_ADD_SEQ_SUB_EN
    en = 1;
`endif
    return (en && s) ? {a >= b, a - b} : {1'b0, a} + {1'b0, b};
  endfunction
  bit m_init = 0, m_busy = 0;
  int m_cnt = 0;
  logic [W-1:0] m_res = '0;
  logic m_co = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_init <= 1; m_busy <= 0; m_cnt <= 0; m_res <= '0; m_co <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1; m_cnt <= 0; {m_co, m_res} <= ref_op(op_a, op_b, op_sub);
      end
    end else if (m_cnt < S) m_cnt <= m_cnt + 1;
    else if (out_ready) m_busy <= 0;
  end
  always @(negedge clk) if (m_init) begin
    chk("in_ready", in_ready, !m_busy);
    chk("out_valid", out_valid, m_busy && m_cnt == S);
    if (!m_busy || m_cnt == S) begin
      chk("result", result, m_res);
      chk("carry_out", carry_out, m_co);
    end
  end
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold,
                        input bit keep, output logic [W-1:0] r, output logic c, output int lat);
    int n;
    r = 'x; c = 1'bx; lat = -1;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = s; in_valid = 1; out_ready = 0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("accept timeout", 0, 1); in_valid = 0; return; end
    @(negedge clk);
    if (!keep) in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) begin chk("out_valid timeout", 0, 1); in_valid = 0; return; end
    lat = n; r = result; c = carry_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold result", result, r);
      chk("hold carry", carry_out, c);
      chk("hold in_ready", in_ready, 0);
      chk("hold out_valid", out_valid, 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0; in_valid = 0;
  endtask
  initial begin
    logic [W-1:0] r;
    logic c;
    int lat;
    repeat (2) @(negedge clk);
    chk("rst result", result, 0);
    chk("rst carry", carry_out, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    rst_n = 1;
    run_op(12'd1, 12'd0, 0, 0, 0, r, c, lat);
    chk("add1 result", r, 1); chk("add1 carry", c, 0); chk("add1 latency", lat, S);
    run_op(12'hFFF, 12'd1, 0, 0, 0, r, c, lat);
    chk("ripple result", r, 0); chk("ripple carry", c, 1);
    run_op(12'd3, 12'd7, 0, 3, 1, r, c, lat);
    chk("bp result", r, 10); chk("bp carry", c, 0);
    @(negedge clk);
    op_a = 12'd9; op_b = 12'd9; op_sub = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort in_ready", in_ready, 1);
    for (int i = 0; i < S + 2; i++) begin
      chk("abort out_valid", out_valid, 0);
      @(negedge clk);
    end
    run_op(12'd5, 12'd1, 0, 0, 0, r, c, lat);
    chk("post abort result", r, 6); chk("post abort carry", c, 0);
`ifdef WIDE_ADD_SEQ_SUB_EN
    run_op(12'd5, 12'd7, 1, 0, 0, r, c, lat);
    chk("sub 5-7 result", r, 12'hFFE); chk("sub 5-7 carry", c, 0);
    run_op(12'd7, 12'd5, 1, 0, 0, r, c, lat);
    chk("sub 7-5 result", r, 2); chk("sub 7-5 carry", c, 1);
`else
    run_op(12'd5, 12'd7, 1, 0, 0, r, c, lat);
    chk("nosub 5,7 result", r, 12); chk("nosub 5,7 carry", c, 0);
    run_op(12'd7, 12'd5, 1, 0, 0, r, c, lat);
    chk("nosub 7,5 result", r, 12); chk("nosub 7,5 carry", c, 0);
`endif
    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), r, c, lat);
      chk("rand latency", lat, S);
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
